// File: rtl/aes_arb_pkg.sv
// ============================================================================
// Module   : aes_arb_pkg
// Brief    : Shared types and constants for the AES engine arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_t;

   // Requester indices (bit positions in the request vector)
   localparam logic REQ_DEC = 1'b0;
   localparam logic REQ_ENC = 1'b1;

   // Core operating modes
   localparam logic MODE_DEC = 1'b0;
   localparam logic MODE_ENC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/aes_arb_rr_pick.sv
// ============================================================================
// Module   : aes_arb_rr_pick
// Brief    : Combinational 2-way round-robin picker. On a tie the requester
//            that was not granted last wins; a lone request always wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_arb_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_idx,
   output logic       gnt_valid
);

   // Tie goes to the opposite of the last grant; otherwise the single requester
   always_comb begin
      gnt_valid = |req;
      if (req == 2'b11) begin
         gnt_idx = ~last;
      end else begin
         gnt_idx = req[1];
      end
   end

endmodule

`default_nettype wire

// File: rtl/aes_engine_arbiter.sv
// ============================================================================
// Module   : aes_engine_arbiter
// Brief    : Shares one AES core between the boot decrypt path (DEC) and the
//            user encrypt path (ENC). Latches the granted operands, launches
//            the core, waits for completion and returns the result with a
//            one-cycle done pulse.
// Option   : AES_ARB_TIMEOUT_EN - adds a WAIT-state watchdog that aborts the
//            core after TIMEOUT_CYC cycles and reports err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_engine_arbiter
   import aes_arb_pkg::*;
#(
   parameter int DATA_W      = 128,
   parameter int KEY_W       = 128,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_req,
   input  logic [KEY_W-1:0]  dec_key,
   input  logic [DATA_W-1:0] dec_din,
   output logic              dec_done,
   input  logic              enc_req,
   input  logic [KEY_W-1:0]  enc_key,
   input  logic [DATA_W-1:0] enc_din,
   output logic              enc_done,
   output logic [DATA_W-1:0] dout,
   output logic              err,
   output logic              busy,
   output logic              core_start,
   output logic              core_mode,
   output logic [KEY_W-1:0]  core_key,
   output logic [DATA_W-1:0] core_din,
   output logic              core_abort,
   input  logic              core_ready,
   input  logic [DATA_W-1:0] core_dout
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              gnt;
   logic              last;
   logic              pick_idx;
   logic              pick_valid;
   logic              tmo_hit;
   logic [DATA_W-1:0] dout_q;

   // Values of TIMEOUT_CYC below 2 are outside the supported range; this
   // scope exists only to mark that case and holds no logic.
   if (TIMEOUT_CYC < 2) begin : g_tmo_range_unsupported
   end

   aes_arb_rr_pick u_pick (
      .req       ({enc_req, dec_req}),
      .last      (last),
      .gnt_idx   (pick_idx),
      .gnt_valid (pick_valid)
   );

`ifdef AES_ARB_TIMEOUT_EN
   localparam int TMO_CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TIMEOUT_CYC - 1);

   logic [TMO_CW-1:0] tmo_cnt;
   logic              err_q;

   assign tmo_hit = (state == ST_WAIT) && (tmo_cnt == TMO_LAST);

   // WAIT-cycle counter: cleared while launching so it starts at 0 in WAIT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (state == ST_LAUNCH) begin
         tmo_cnt <= '0;
      end else if (state == ST_WAIT) begin
         tmo_cnt <= tmo_cnt + TMO_CW'(1);
      end
   end

   // Error flag: set on watchdog expiry, a same-cycle ready result wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (state == ST_WAIT) begin
         if (core_ready) begin
            err_q <= 1'b0;
         end else if (tmo_hit) begin
            err_q <= 1'b1;
         end
      end else if (state == ST_RESP) begin
         err_q <= 1'b0;
      end
   end

   assign err        = err_q;
   assign core_abort = (state == ST_RESP) && err_q;
`else
   assign tmo_hit    = 1'b0;
   assign err        = 1'b0;
   assign core_abort = 1'b0;
`endif

   // Next-state decode; core_ready only matters in WAIT
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (pick_valid) state_nxt = ST_LAUNCH;
         ST_LAUNCH: state_nxt = ST_WAIT;
         ST_WAIT:   if (core_ready || tmo_hit) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State, grant/operand latching, result capture and round-robin pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         gnt       <= REQ_DEC;
         last      <= REQ_ENC;
         core_mode <= MODE_DEC;
         core_key  <= '0;
         core_din  <= '0;
         dout_q    <= '0;
      end else begin
         state <= state_nxt;
         if ((state == ST_IDLE) && pick_valid) begin
            gnt <= pick_idx;
            if (pick_idx == REQ_ENC) begin
               core_mode <= MODE_ENC;
               core_key  <= enc_key;
               core_din  <= enc_din;
            end else begin
               core_mode <= MODE_DEC;
               core_key  <= dec_key;
               core_din  <= dec_din;
            end
         end
         if ((state == ST_WAIT) && core_ready) begin
            dout_q <= core_dout;
         end else if (state == ST_RESP) begin
            dout_q <= '0;
            last   <= gnt;
         end
      end
   end

   assign busy       = (state != ST_IDLE);
   assign core_start = (state == ST_LAUNCH);
   assign dec_done   = (state == ST_RESP) && (gnt == REQ_DEC);
   assign enc_done   = (state == ST_RESP) && (gnt == REQ_ENC);
   assign dout       = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_engine_arbiter.sv
// ============================================================================
// Module   : tb_aes_engine_arbiter
// Brief    : Directed self-checking bench for aes_engine_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_engine_arbiter;

   localparam int DW = 128;
   localparam int KW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          dec_req, enc_req;
   logic [KW-1:0] dec_key, enc_key;
   logic [DW-1:0] dec_din, enc_din;
   logic          dec_done, enc_done;
   logic [DW-1:0] dout;
   logic          err, busy, core_start, core_mode, core_abort;
   logic [KW-1:0] core_key;
   logic [DW-1:0] core_din;
   logic          core_ready;
   logic [DW-1:0] core_dout;

   int compared   = 0;
   int mismatched = 0;

   aes_engine_arbiter #(
      .DATA_W      (DW),
      .KEY_W       (KW),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dec_req    (dec_req),
      .dec_key    (dec_key),
      .dec_din    (dec_din),
      .dec_done   (dec_done),
      .enc_req    (enc_req),
      .enc_key    (enc_key),
      .enc_din    (enc_din),
      .enc_done   (enc_done),
      .dout       (dout),
      .err        (err),
      .busy       (busy),
      .core_start (core_start),
      .core_mode  (core_mode),
      .core_key   (core_key),
      .core_din   (core_din),
      .core_abort (core_abort),
      .core_ready (core_ready),
      .core_dout  (core_dout)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      dec_req = 1'b0; enc_req = 1'b0; core_ready = 1'b0;
      dec_key = 128'h1111; dec_din = 128'h2222;
      enc_key = 128'h3333; enc_din = 128'h4444;
      core_dout = 128'h5555;
      step(); step();
      compared++;
      if ({busy, core_start, core_mode, err, core_abort, dec_done, enc_done} !== 7'b0) begin
         mismatched++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {busy, core_start, core_mode, err, core_abort, dec_done, enc_done});
      end
      compared++;
      if (core_key !== '0 || core_din !== '0 || dout !== '0) begin
         mismatched++;
         $display("FAIL reset_data: key=%h din=%h dout=%h want all 0", core_key, core_din, dout);
      end
      rst = 1'b1;
      step();
   endtask

   // Both requests held from reset: grants alternate DEC, ENC, DEC, ENC
   task automatic test_tie();
      int gi = 0;
      int idle_run = 0;
      int pend = 0;
      bit prev_done = 1'b0;
      dec_req = 1'b1; enc_req = 1'b1;
      for (int c = 1; c <= 60 && gi < 4; c++) begin
         step();
         if (core_start) begin
            compared++;
            if (core_mode !== 1'(gi % 2)) begin
               mismatched++;
               $display("FAIL tie_mode[%0d]: got %b want %b", gi, core_mode, 1'(gi % 2));
            end
         end
         if (dec_done || enc_done) begin
            compared++;
            if ({enc_done, dec_done} !== ((gi % 2 == 0) ? 2'b01 : 2'b10)) begin
               mismatched++;
               $display("FAIL tie_grant[%0d]: got enc/dec=%b%b", gi, enc_done, dec_done);
            end
            compared++;
            if (prev_done) begin
               mismatched++;
               $display("FAIL tie_done_width[%0d]: got 2+ cycles want 1", gi);
            end
            if (gi > 0) begin
               compared++;
               if (idle_run !== 1) begin
                  mismatched++;
                  $display("FAIL tie_idle_gap[%0d]: got %0d want 1", gi, idle_run);
               end
            end
            gi++;
            idle_run = 0;
            if (gi == 4) begin
               dec_req = 1'b0; enc_req = 1'b0;
            end
         end
         if (!busy) idle_run++;
         prev_done = dec_done | enc_done;
         if (core_start) pend = 3;
         else if (pend > 0) pend--;
         core_ready = (pend == 1);
      end
      compared++;
      if (gi !== 4) begin
         mismatched++;
         $display("FAIL tie_timeout: got %0d grants want 4", gi);
      end
      core_ready = 1'b0;
      step(); step();
   endtask

   task automatic test_single_dec();
      int ndec = 0;
      int nenc = 0;
      dec_key   = 128'h000102030405060708090a0b0c0d0e0f;
      dec_din   = {16{8'hAA}};
      core_dout = {16{8'h55}};
      dec_req   = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (dec_done) ndec++;
         if (enc_done) nenc++;
         if (c == 1) begin
            compared++;
            if (core_start !== 1'b1 || core_mode !== 1'b0) begin
               mismatched++;
               $display("FAIL dec_launch: start=%b mode=%b want 1 0", core_start, core_mode);
            end
            compared++;
            if (core_key !== 128'h000102030405060708090a0b0c0d0e0f || core_din !== {16{8'hAA}}) begin
               mismatched++;
               $display("FAIL dec_operands: key=%h din=%h", core_key, core_din);
            end
         end
         if (c == 2) begin
            compared++;
            if (core_start !== 1'b0) begin
               mismatched++;
               $display("FAIL dec_start_width: got %b want 0", core_start);
            end
         end
         if (c == 12) begin
            compared++;
            if (dec_done !== 1'b0 || dout !== '0) begin
               mismatched++;
               $display("FAIL dec_early: done=%b dout=%h want 0", dec_done, dout);
            end
         end
         if (c == 13) begin
            compared++;
            if (dec_done !== 1'b1 || dout !== {16{8'h55}} || err !== 1'b0) begin
               mismatched++;
               $display("FAIL dec_result: done=%b dout=%h err=%b", dec_done, dout, err);
            end
            dec_req = 1'b0;
         end
         core_ready = (c == 12);
      end
      compared++;
      if (ndec !== 1 || nenc !== 0) begin
         mismatched++;
         $display("FAIL dec_done_count: dec=%0d enc=%0d want 1 0", ndec, nenc);
      end
   endtask

   task automatic test_stray_ready();
      core_dout  = 128'hDEADBEEF_00000000_12345678_9ABCDEF0;
      core_ready = 1'b1;
      step();
      compared++;
      if (busy !== 1'b0 || dec_done !== 1'b0 || enc_done !== 1'b0) begin
         mismatched++;
         $display("FAIL stray_idle: busy=%b dd=%b ed=%b want 0", busy, dec_done, enc_done);
      end
      core_ready = 1'b0;
      enc_req    = 1'b1;
      step();
      core_ready = 1'b1;
      step();
      compared++;
      if (busy !== 1'b1 || core_start !== 1'b0 || enc_done !== 1'b0) begin
         mismatched++;
         $display("FAIL stray_launch: busy=%b start=%b ed=%b want 1 0 0", busy, core_start, enc_done);
      end
      core_ready = 1'b0;
      step();
      compared++;
      if (enc_done !== 1'b0 || dout !== '0) begin
         mismatched++;
         $display("FAIL stray_wait: ed=%b dout=%h want 0 0", enc_done, dout);
      end
      core_ready = 1'b1;
      step();
      compared++;
      if (enc_done !== 1'b1 || dout !== 128'hDEADBEEF_00000000_12345678_9ABCDEF0) begin
         mismatched++;
         $display("FAIL stray_result: ed=%b dout=%h", enc_done, dout);
      end
      core_ready = 1'b0;
      enc_req    = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_wait();
      int ndone = 0;
      enc_key = 128'hFFEE; enc_din = 128'hCCBB;
      enc_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         if (dec_done || enc_done) ndone++;
      end
      #3;
      rst = 1'b0;
      #1;
      compared++;
      if ({busy, core_start, core_mode, err, core_abort, dec_done, enc_done} !== 7'b0 ||
          core_key !== '0 || core_din !== '0 || dout !== '0) begin
         mismatched++;
         $display("FAIL rst_async: ctrl=%b key=%h din=%h dout=%h want all 0",
                  {busy, core_start, core_mode, err, core_abort, dec_done, enc_done},
                  core_key, core_din, dout);
      end
      dec_req = 1'b1;
      step();
      if (dec_done || enc_done) ndone++;
      rst = 1'b1;
      step();
      compared++;
      if (core_start !== 1'b1 || core_mode !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_tie_dec: start=%b mode=%b want 1 0", core_start, core_mode);
      end
      compared++;
      if (ndone !== 0) begin
         mismatched++;
         $display("FAIL rst_no_done: got %0d pulses want 0", ndone);
      end
      enc_req = 1'b0;
      step();
      core_ready = 1'b1;
      step();
      compared++;
      if (dec_done !== 1'b1 || enc_done !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_tie_done: dd=%b ed=%b want 1 0", dec_done, enc_done);
      end
      core_ready = 1'b0;
      dec_req    = 1'b0;
      step();
   endtask

`ifdef AES_ARB_TIMEOUT_EN
   task automatic test_timeout();
      core_dout  = {16{8'hC3}};
      core_ready = 1'b0;
      enc_req    = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 9) begin
            compared++;
            if (enc_done !== 1'b0) begin
               mismatched++;
               $display("FAIL tmo_early: ed=%b want 0", enc_done);
            end
         end
         if (c == 10) begin
            compared++;
            if (enc_done !== 1'b1 || err !== 1'b1 || dout !== '0 || core_abort !== 1'b1) begin
               mismatched++;
               $display("FAIL tmo_abort: ed=%b err=%b abort=%b dout=%h want 1 1 1 0",
                        enc_done, err, core_abort, dout);
            end
            enc_req = 1'b0;
         end
         if (c == 11) begin
            compared++;
            if (core_abort !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
               mismatched++;
               $display("FAIL tmo_after: abort=%b err=%b busy=%b want 0", core_abort, err, busy);
            end
         end
      end
   endtask
`else
   task automatic test_timeout();
      int ndone = 0;
      core_ready = 1'b0;
      enc_req    = 1'b1;
      for (int c = 1; c <= 1000; c++) begin
         step();
         if (dec_done || enc_done) ndone++;
      end
      compared++;
      if (busy !== 1'b1 || ndone !== 0) begin
         mismatched++;
         $display("FAIL hang_busy: busy=%b dones=%0d want 1 0", busy, ndone);
      end
      core_dout  = {16{8'h3C}};
      core_ready = 1'b1;
      step();
      compared++;
      if (enc_done !== 1'b1 || err !== 1'b0 || dout !== {16{8'h3C}}) begin
         mismatched++;
         $display("FAIL hang_release: ed=%b err=%b dout=%h", enc_done, err, dout);
      end
      core_ready = 1'b0;
      enc_req    = 1'b0;
      step();
   endtask
`endif

   // Ready on the last WAIT cycle before the watchdog would fire
   task automatic test_boundary();
      core_dout  = 128'h0123456789ABCDEF_FEDCBA9876543210;
      core_ready = 1'b0;
      enc_req    = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 9) begin
            compared++;
            if (enc_done !== 1'b0) begin
               mismatched++;
               $display("FAIL bnd_early: ed=%b want 0", enc_done);
            end
         end
         if (c == 10) begin
            compared++;
            if (enc_done !== 1'b1 || err !== 1'b0 || core_abort !== 1'b0 ||
                dout !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin
               mismatched++;
               $display("FAIL bnd_result: ed=%b err=%b abort=%b dout=%h",
                        enc_done, err, core_abort, dout);
            end
            enc_req = 1'b0;
         end
         core_ready = (c == 9);
      end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_single_dec();
      test_stray_ready();
      test_reset_mid_wait();
      test_timeout();
      test_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
